// File: rtl/xood_op_sequencer.sv
// xood_op_sequencer: steps a permutation core through
// INIT -> NONCE -> ASSOC* -> [RATCHET] -> CRYPT* -> SQUEEZE -> DONE
// with one launch pulse per op and a stall watchdog.
// Optional feature macro: XOOD_SEQ_RATCHET_EN (adds the RATCHET op after assoc).
module xood_op_sequencer (
  input  logic       eph1,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_decrypt,
  input  logic [3:0] cmd_ad_blocks,
  input  logic [3:0] cmd_txt_blocks,
  input  logic       cmd_ratchet,
  input  logic       abort,
  output logic [5:0] core_opmode,
  output logic       core_start,
  input  logic       core_finished,
  output logic [3:0] blk_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WD_W  = 8;

  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(254);

  localparam logic [3:0] OP_INIT    = 4'h1;
  localparam logic [3:0] OP_NONCE   = 4'h2;
  localparam logic [3:0] OP_ASSOC   = 4'h3;
  localparam logic [3:0] OP_CRYPT   = 4'h4;
  localparam logic [3:0] OP_DECRYPT = 4'h5;
  localparam logic [3:0] OP_SQUEEZE = 4'h6;
`ifdef XOOD_SEQ_RATCHET_EN
  localparam logic [3:0] OP_RATCHET = 4'h7;
`endif

  typedef enum logic [3:0] {
    IDLE, INIT, NONCE, ASSOC, RATCHET, CRYPT, SQUEEZE, DONE, ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ad_last;
  logic [CNT_W-1:0] txt_last;
  logic             decrypt_q;
  logic [WD_W-1:0]  wd;
`ifdef XOOD_SEQ_RATCHET_EN
  logic             ratchet_q;
`else
  logic             unused_ratchet;
  assign unused_ratchet = cmd_ratchet;
`endif

  // Completion only counts outside a launch cycle.
  logic             fin_c;
  logic [CNT_W-1:0] next_blk_c;
  logic [3:0]       crypt_op_c;
  assign fin_c      = core_finished & ~core_start;
  assign next_blk_c = blk_idx + CNT_W'(1);
  assign crypt_op_c = decrypt_q ? OP_DECRYPT : OP_CRYPT;

  function automatic logic [5:0] opm(input logic last, input logic [3:0] op);
    return {1'b1, last, op};
  endfunction

  // Sequencer FSM with registered core command and status outputs.
  always_ff @(posedge eph1) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      core_opmode <= 6'h00;
      core_start  <= 1'b0;
      blk_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wd          <= '0;
      ad_last     <= '0;
      txt_last    <= '0;
      decrypt_q   <= 1'b0;
`ifdef XOOD_SEQ_RATCHET_EN
      ratchet_q   <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        cmd_ready   <= 1'b1;
        core_opmode <= 6'h00;
        blk_idx     <= '0;
        busy        <= 1'b0;
        err         <= 1'b0;
        wd          <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              state       <= INIT;
              cmd_ready   <= 1'b0;
              busy        <= 1'b1;
              core_opmode <= opm(1'b0, OP_INIT);
              core_start  <= 1'b1;
              wd          <= '0;
              ad_last     <= (cmd_ad_blocks == '0) ? '0 : cmd_ad_blocks - CNT_W'(1);
              txt_last    <= (cmd_txt_blocks == '0) ? '0 : cmd_txt_blocks - CNT_W'(1);
              decrypt_q   <= cmd_decrypt;
`ifdef XOOD_SEQ_RATCHET_EN
              ratchet_q   <= cmd_ratchet;
`endif
            end
          end
          INIT, NONCE, ASSOC, RATCHET, CRYPT, SQUEEZE: begin
            if (fin_c) begin
              wd         <= '0;
              core_start <= 1'b1;
              case (state)
                INIT: begin
                  state       <= NONCE;
                  core_opmode <= opm(1'b0, OP_NONCE);
                end
                NONCE: begin
                  state       <= ASSOC;
                  blk_idx     <= '0;
                  core_opmode <= opm(ad_last == '0, OP_ASSOC);
                end
                ASSOC: begin
                  blk_idx <= '0;
                  if (blk_idx != ad_last) begin
                    blk_idx     <= next_blk_c;
                    core_opmode <= opm(next_blk_c == ad_last, OP_ASSOC);
                  end
`ifdef XOOD_SEQ_RATCHET_EN
                  else if (ratchet_q) begin
                    state       <= RATCHET;
                    core_opmode <= opm(1'b0, OP_RATCHET);
                  end
`endif
                  else begin
                    state       <= CRYPT;
                    core_opmode <= opm(txt_last == '0, crypt_op_c);
                  end
                end
`ifdef XOOD_SEQ_RATCHET_EN
                RATCHET: begin
                  state       <= CRYPT;
                  blk_idx     <= '0;
                  core_opmode <= opm(txt_last == '0, crypt_op_c);
                end
`endif
                CRYPT: begin
                  if (blk_idx != txt_last) begin
                    blk_idx     <= next_blk_c;
                    core_opmode <= opm(next_blk_c == txt_last, crypt_op_c);
                  end else begin
                    state       <= SQUEEZE;
                    blk_idx     <= '0;
                    core_opmode <= opm(1'b1, OP_SQUEEZE);
                  end
                end
                SQUEEZE: begin
                  state       <= DONE;
                  core_start  <= 1'b0;
                  core_opmode <= 6'h00;
                  blk_idx     <= '0;
                  done        <= 1'b1;
                end
                default: begin
                  state       <= IDLE;
                  core_start  <= 1'b0;
                  core_opmode <= 6'h00;
                  blk_idx     <= '0;
                  busy        <= 1'b0;
                  cmd_ready   <= 1'b1;
                end
              endcase
            end else if (!core_start && wd == WD_TRIP) begin
              state       <= ERR;
              err         <= 1'b1;
              core_opmode <= 6'h00;
              blk_idx     <= '0;
              wd          <= wd + WD_W'(1);
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
          DONE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
          ERR: begin
            state <= ERR;
          end
          default: begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            core_opmode <= 6'h00;
            blk_idx     <= '0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
